// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule definitions.
//   state_t  - key-schedule FSM encoding (IDLE / FWD / EMIT)
//   rcon()   - round-constant table, index 1..10 (0 and >10 read as 0)
//   gf_mul() - GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_EMIT
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      m = m >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/key_step.sv
// key_step: one AES-128 key-schedule step, forward or inverse.
//   i_key  - current round key, bit 0 = MSB of byte 0
//   i_rcon - round constant for this step
//   i_inv  - 0: forward step, 1: inverse step
//   o_key  - next (or previous) round key
// A single 4-byte SubWord serves both directions; only its source word differs.
module key_step (
  input  logic [0:127] i_key,
  input  logic [7:0]   i_rcon,
  input  logic         i_inv,
  output logic [0:127] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_src, w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = i_key[0:31];
  assign w_w1 = i_key[32:63];
  assign w_w2 = i_key[64:95];
  assign w_w3 = i_key[96:127];

  // inverse direction recovers the previous w3 first and feeds it to SubWord
  assign w_src = i_inv ? (w_w3 ^ w_w2) : w_w3;
  assign w_rot = {w_src[23:0], w_src[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    s_box u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_t = w_sub ^ {i_rcon, 24'h0};

  always_comb begin
    w_n0 = '0;
    w_n1 = '0;
    w_n2 = '0;
    w_n3 = '0;
    if (i_inv) begin
      w_n0 = w_w0 ^ w_t;
      w_n1 = w_w1 ^ w_w0;
      w_n2 = w_w2 ^ w_w1;
      w_n3 = w_w3 ^ w_w2;
    end else begin
      w_n0 = w_w0 ^ w_t;
      w_n1 = w_w1 ^ w_n0;
      w_n2 = w_w2 ^ w_n1;
      w_n3 = w_w3 ^ w_n2;
    end
    o_key = {w_n0, w_n1, w_n2, w_n3};
  end

endmodule

// File: rtl/s_box.sv
// s_box: combinational AES forward S-box.
//   i_byte - input byte
//   o_byte - substituted byte
// Computed as multiplicative inverse (x^254) followed by the AES affine map,
// rather than a 256-entry table.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128;
  logic [7:0] w_inv;

  always_comb begin
    w_x2   = gf_mul(i_byte, i_byte);
    w_x4   = gf_mul(w_x2, w_x2);
    w_x8   = gf_mul(w_x4, w_x4);
    w_x16  = gf_mul(w_x8, w_x8);
    w_x32  = gf_mul(w_x16, w_x16);
    w_x64  = gf_mul(w_x32, w_x32);
    w_x128 = gf_mul(w_x64, w_x64);
    // 2+4+8+16+32+64+128 = 254; 0 maps to 0 as required
    w_inv  = gf_mul(gf_mul(gf_mul(w_x2, w_x4), gf_mul(w_x8, w_x16)),
                    gf_mul(gf_mul(w_x32, w_x64), w_x128));
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                   ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched: AES-128 decryption key scheduler.
// Expands the cipher key forward to round NR, then streams round keys
// NR down to 0 over a valid/ready handshake, stepping backwards in place.
//   clk, rst_n         - clock, synchronous active-low reset
//   start, cipher_key  - begin a schedule (sampled in IDLE only)
//   busy               - high whenever not IDLE
//   rk_valid, rk_ready - round-key handshake
//   rk_out, rk_round   - round key and its index
//   done               - one-cycle pulse after round 0 is accepted
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] cipher_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       r_state;
  logic [0:127] r_key;
  logic [3:0]   r_cnt;
  logic [3:0]   r_round;
  logic         r_busy;
  logic         r_valid;
  logic         r_done;

  logic         w_inv;
  logic [7:0]   w_rcon;
  logic [0:127] w_next;

  // FWD and EMIT never overlap, so one key_step is shared between them
  assign w_inv  = (r_state == ST_EMIT);
  assign w_rcon = rcon(w_inv ? r_round : r_cnt);

  key_step u_step (
    .i_key  (r_key),
    .i_rcon (w_rcon),
    .i_inv  (w_inv),
    .o_key  (w_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_round <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key   <= cipher_key;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= ST_FWD;
          end
        end
        ST_FWD: begin
          r_key <= w_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_RND) begin
            r_round <= LAST_RND;
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (r_round != 4'd0) begin
              r_key   <= w_next;
              r_round <= r_round - 4'd1;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign done     = r_done;
  // key_reg is non-zero in FWD and after a schedule; only expose it in EMIT
  assign rk_out   = r_valid ? r_key : '0;
  assign rk_round = r_round;

endmodule

// File: tb/tb_inv_key_sched.sv
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         busy;
  logic         rk_valid;
  logic         done;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  inv_key_sched #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_out     (rk_out),
    .rk_round   (rk_round),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  // Textbook forward expansion into 44 words; round r = words 4r..4r+3.
  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic do_start(input logic [127:0] key);
    cipher_key = key;
    start      = 1'b1;
    ref_expand(key);
    for (int r = 0; r < 11; r++) got_rk[r] = 'x;
  endtask

  // Called at a negedge with start already driven; returns at the negedge of
  // the done cycle (or right after a mid-EMIT reset when abort_at matches).
  task automatic run_sched(input bit rnd_ready, input bit spam, input int abort_at,
                           output bit aborted);
    int k;
    int exp_round;
    bit pend;
    bit fin;
    bit seen;
    k = 0; exp_round = 10; pend = 0; fin = 0; seen = 0; aborted = 0;
    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_after_start", 128'(busy), 128'(1'b1));
      if (!pend && done) chk("spurious_done", 128'(done), 128'(1'b0));
      if (pend) begin
        chk("done_pulse", 128'(done), 128'(1'b1));
        chk("valid_after_last", 128'(rk_valid), 128'(1'b0));
        chk("busy_after_last", 128'(busy), 128'(1'b0));
        chk("rk_out_after_last", rk_out, 128'h0);
        fin = 1;
      end else if (rk_valid) begin
        if (!seen) begin
          seen = 1;
          chk("first_valid_latency", 128'(k), 128'd11);
        end
        chk("rk_round", 128'(rk_round), 128'(exp_round));
        chk("rk_out", rk_out, exp_rk[exp_round]);
        chk("busy_in_emit", 128'(busy), 128'(1'b1));
        got_rk[exp_round] = rk_out;
        if (exp_round == abort_at) begin
          rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0;
          @(negedge clk);
          chk("rst_busy", 128'(busy), 128'(1'b0));
          chk("rst_valid", 128'(rk_valid), 128'(1'b0));
          chk("rst_done", 128'(done), 128'(1'b0));
          chk("rst_rk_out", rk_out, 128'h0);
          chk("rst_rk_round", 128'(rk_round), 128'h0);
          rst_n = 1'b1;
          aborted = 1;
          fin = 1;
        end else begin
          rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (rk_ready) begin
            if (exp_round == 0) pend = 1;
            else exp_round--;
          end
        end
      end else begin
        if (seen) chk("valid_dropped", 128'(rk_valid), 128'(1'b1));
        if (k > 1) chk("busy_in_fwd", 128'(busy), 128'(1'b1));
        rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (fin) begin
        start    = 1'b0;
        rk_ready = 1'b0;
      end else begin
        start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        if (spam) cipher_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    if (!fin) chk("timeout", 128'(1'b0), 128'(1'b1));
  endtask

  initial begin
    bit ab;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(1'b0));
    chk("reset_valid", 128'(rk_valid), 128'(1'b0));
    chk("reset_done", 128'(done), 128'(1'b0));
    chk("reset_rk_out", rk_out, 128'h0);
    chk("reset_rk_round", 128'(rk_round), 128'h0);

    rst_n = 1'b1; rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_busy", 128'(busy), 128'(1'b0));
    chk("idle_ready_valid", 128'(rk_valid), 128'(1'b0));
    rk_ready = 1'b0;

    // FIPS-197 A.1 key, consumer always ready
    do_start(FIPS_KEY);
    run_sched(0, 0, -1, ab);
    chk("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r9",  got_rk[9],  128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r1",  got_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r0",  got_rk[0],  FIPS_KEY);
    @(negedge clk);
    chk("done_single_pulse", 128'(done), 128'(1'b0));

    // random backpressure
    do_start(FIPS_KEY);
    run_sched(1, 0, -1, ab);
    chk("stall_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("stall_r0",  got_rk[0],  FIPS_KEY);

    // start hammered during FWD and EMIT
    do_start(FIPS_KEY);
    run_sched(1, 1, -1, ab);
    chk("spam_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("spam_r0", got_rk[0], FIPS_KEY);

    // reset at round 5 of EMIT, then a clean run
    do_start(FIPS_KEY);
    run_sched(0, 0, 5, ab);
    chk("abort_taken", 128'(ab), 128'(1'b1));
    do_start(FIPS_KEY);
    run_sched(0, 0, -1, ab);
    chk("post_rst_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // back-to-back: second start issued in the done cycle
    do_start(FIPS_KEY);
    run_sched(0, 0, -1, ab);
    do_start(SEQ_KEY);
    run_sched(0, 0, -1, ab);
    chk("b2b_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("b2b_r0",  got_rk[0],  SEQ_KEY);

    // random keys against the reference expansion
    for (int n = 0; n < 1000; n++) begin
      do_start({$urandom(), $urandom(), $urandom(), $urandom()});
      run_sched(0, 0, -1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
